// File: rtl/uart_pkg.sv
// Shared byte width and arbiter state encoding for the UART transmit path.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first set request bit at or after ptr, modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // One spare bit holds ptr+i before folding it back below N.
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte-stream requesters.
//   state   | meaning
//   ST_IDLE | no owner; pick next requester at/after ptr
//   ST_OWN  | grant owns the transmitter until last byte or burst cap
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        s_valid_i,
    output logic [NUM_REQ-1:0]        s_ready_o,
    input  logic [BYTE_W*NUM_REQ-1:0] s_data_i,
    input  logic [NUM_REQ-1:0]        s_last_i,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [BYTE_W-1:0]         wdata_o,
    output logic [IDX_W-1:0]          grant_o,
    output logic                      busy_o
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [7:0]       burst_cnt, burst_cnt_nxt;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              own;
    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic              xfer;
    logic              cap_hit;
    logic [IDX_W-1:0]  grant_inc;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (s_valid_i),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Outputs are held quiet while reset is asserted, not just after the first edge.
    assign own         = rst_ni && (state == ST_OWN);
    assign owner_valid = s_valid_i[grant];
    assign owner_last  = s_last_i[grant];
    assign owner_data  = s_data_i[grant*BYTE_W +: BYTE_W];
    assign xfer        = own && owner_valid && wready_i;
    assign cap_hit     = (burst_cnt + 8'd1) == BURST_MAX;
    assign grant_inc   = (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + IDX_W'(1);

    always_comb begin
        s_ready_o = '0;
        if (own) begin
            s_ready_o[grant] = wready_i;
        end
        wvalid_o = own && owner_valid;
        wdata_o  = (own && owner_valid) ? owner_data : '0;
        grant_o  = own ? grant : '0;
        busy_o   = own;
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = grant;
        burst_cnt_nxt = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_OWN;
                end
            end
            ST_OWN: begin
                if (xfer) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (owner_last || cap_hit) begin
                        state_nxt = ST_IDLE;
                        ptr_nxt   = grant_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule
